// File: rtl/alu_op_sequencer_if.sv
// Handshake, ALU-drive and debug-read signals between alu_op_sequencer and its surroundings.
// The slave modport is the sequencer's view; the master modport is the instruction source / ALU side.
interface alu_op_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_neg;
  logic        done;
  logic [7:0]  result;
  logic [2:0]  flags;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  modport slave (
    input  instr_valid, instr, alu_out, alu_carry, alu_zero, alu_neg, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_sel, done, result, flags, dbg_data
  );

  modport master (
    output instr_valid, instr, alu_out, alu_carry, alu_zero, alu_neg, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_sel, done, result, flags, dbg_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Three-cycle operand sequencer for the 8-bit ALU: latches operands from a 4x8 register file,
// writes the ALU result back and captures the ALU flags.
module alu_op_sequencer #(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic [1:0]      rd_q, rd_d;
  logic [3:0][7:0] rf_q, rf_d;
  logic [7:0]      result_q, result_d;
  logic [2:0]      flags_q, flags_d;

  logic [2:0] op_f;
  logic       imm_en_f;
  logic [1:0] rd_f, ra_f, rb_f;
  logic [7:0] imm8_f;

  assign op_f     = bus.instr[15:13];
  assign imm_en_f = bus.instr[12];
  assign rd_f     = bus.instr[11:10];
  assign ra_f     = bus.instr[9:8];
  assign imm8_f   = bus.instr[7:0];
  assign rb_f     = bus.instr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_sel_q <= 3'b000;
      rd_q      <= 2'b00;
      rf_q      <= {4{REG_INIT}};
      result_q  <= 8'h00;
      flags_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      rd_q      <= rd_d;
      rf_q      <= rf_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    rd_d      = rd_q;
    rf_d      = rf_q;
    result_d  = result_q;
    flags_d   = flags_q;
    unique case (state_q)
      IDLE: begin
        // instr_ready is high throughout IDLE, so valid alone completes the handshake
        if (bus.instr_valid) begin
          alu_sel_d = op_f;
          rd_d      = rd_f;
          alu_a_d   = rf_q[ra_f];
          alu_b_d   = imm_en_f ? imm8_f : rf_q[rb_f];
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rf_d[rd_q] = bus.alu_out;
        result_d   = bus.alu_out;
        flags_d    = {bus.alu_carry, bus.alu_zero, bus.alu_neg};
        state_d    = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.done        = (state_q == WB);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.result      = result_q;
  assign bus.flags       = flags_q;
  assign bus.dbg_data    = rf_q[bus.dbg_addr];

endmodule
